alu_control_muldiv_sequencer: RTL

//  EX-stage ALU control, next generation. Full 6-bit funct decode to 4-bit ALU control.

---
 rtl/alu_control_muldiv_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_control_muldiv_sequencer.sv
// EX-stage ALU control decode plus an iterative mul/div sequencer that owns HI/LO.
// Stalls the front of the pipeline for WIDTH+1 cycles per MULT/MULTU/DIV/DIVU.
module alu_control_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [1:0]       alu_operation,
    input  logic [5:0]       function_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [3:0]       alu_control_signal,
    output logic             hilo_select,
    output logic [WIDTH-1:0] hilo_result,
    output logic             stall,
    output logic             muldiv_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_XOR = 4'b1101;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_SLT = 4'b0111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_n;

    logic             is_r;
    logic             f_mult, f_multu, f_div, f_divu;
    logic             f_mfhi, f_mflo, f_mthi, f_mtlo;
    logic             is_mul, is_div, op_signed;
    logic             start, busy, last;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] acc, quo, mop, a_raw;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc_n, quo_n;
    logic [WIDTH:0]   add_sum, pp, shifted;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_r    = (alu_operation == 2'b10);
    assign f_mult  = is_r && (function_code == 6'b011000);
    assign f_multu = is_r && (function_code == 6'b011001);
    assign f_div   = is_r && (function_code == 6'b011010);
    assign f_divu  = is_r && (function_code == 6'b011011);
    assign f_mfhi  = is_r && (function_code == 6'b010000);
    assign f_mthi  = is_r && (function_code == 6'b010001);
    assign f_mflo  = is_r && (function_code == 6'b010010);
    assign f_mtlo  = is_r && (function_code == 6'b010011);

    assign is_mul    = f_mult | f_multu;
    assign is_div    = f_div | f_divu;
    assign op_signed = f_mult | f_div;

    // Reset gates start so stall stays low during a reset cycle.
    assign start = issue_valid && (is_mul || is_div)
                   && (state == IDLE) && !reset;
    assign busy  = (state == MUL) || (state == DIV);
    assign last  = (count == CW'(WIDTH - 1));

    assign stall       = start || busy;
    assign muldiv_done = (state == DONE);

    always_comb begin
        alu_control_signal = CTL_ADD;
        unique case (alu_operation)
            2'b01: alu_control_signal = CTL_SUB;
            2'b10: begin
                unique case (1'b1)
                    function_code[5:1] == 5'b10000: alu_control_signal = CTL_ADD;
                    function_code[5:1] == 5'b10001: alu_control_signal = CTL_SUB;
                    function_code == 6'b100100:     alu_control_signal = CTL_AND;
                    function_code == 6'b100101:     alu_control_signal = CTL_OR;
                    function_code == 6'b100110:     alu_control_signal = CTL_XOR;
                    function_code == 6'b100111:     alu_control_signal = CTL_NOR;
                    function_code == 6'b101010:     alu_control_signal = CTL_SLT;
                    default:                        alu_control_signal = CTL_ADD;
                endcase
            end
            default: alu_control_signal = CTL_ADD;
        endcase
    end

    assign hilo_select = f_mfhi | f_mflo;
    assign hilo_result = f_mfhi ? hi : (f_mflo ? lo : '0);

    assign mag_a = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign mag_b = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // acc = product high / remainder, quo = multiplier / quotient, mop = the other operand
    always_comb begin
        add_sum = {1'b0, acc} + {1'b0, mop};
        pp      = quo[0] ? add_sum : {1'b0, acc};
        shifted = {acc, quo[WIDTH-1]};
        acc_n   = acc;
        quo_n   = quo;
        if (state == MUL) begin
            acc_n = pp[WIDTH:1];
            quo_n = {pp[0], quo[WIDTH-1:1]};
        end else if (shifted >= {1'b0, mop}) begin
            acc_n = WIDTH'(shifted - {1'b0, mop});
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        prod     = {acc_n, quo_n};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = (sign_a ^ sign_b) ? -quo_n : quo_n;
        rem_fix  = sign_a ? -acc_n : acc_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = is_mul ? MUL : DIV;
            MUL:  if (last) state_n = DONE;
            DIV:  if (last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            quo    <= '0;
            mop    <= '0;
            a_raw  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                acc    <= '0;
                quo    <= is_mul ? mag_b : mag_a;
                mop    <= is_mul ? mag_a : mag_b;
                a_raw  <= operand_a;
                sign_a <= op_signed && operand_a[WIDTH-1];
                sign_b <= op_signed && operand_b[WIDTH-1];
                count  <= '0;
            end else if (busy) begin
                acc   <= acc_n;
                quo   <= quo_n;
                count <= count + 1'b1;
                if (last && state == MUL) begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end else if (last && mop == '0) begin
                    hi <= a_raw;
                    lo <= '1;
                end else if (last) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end
            if (issue_valid && state == IDLE && f_mthi) hi <= operand_a;
            if (issue_valid && state == IDLE && f_mtlo) lo <= operand_a;
        end
    end

endmodule
